// File: rtl/obq_ctrl_pkg.sv
// Shared types and sizing for the outstanding branch queue controller.
// Tags are logical modulo counters; indices count rows, including the "full" value.
package obq_ctrl_pkg;

    localparam int OBQ_SIZE  = 16;
    localparam int RET_W     = 2;
    localparam int TAG_W     = $clog2(OBQ_SIZE) + 2;
    localparam int IDX_W     = $clog2(OBQ_SIZE) + 1;
    localparam int RET_CNT_W = $clog2(RET_W + 1);

    typedef logic [TAG_W-1:0]     obq_tag_t;
    typedef logic [IDX_W-1:0]     obq_idx_t;
    typedef logic [RET_CNT_W-1:0] obq_ret_t;

    typedef enum logic {
        OBQC_NORMAL,
        OBQC_RECOVER
    } obq_ctrl_state_t;

endpackage

// File: rtl/obq_ctrl_tag_xlate.sv
// Logical tag to physical OBQ row translation; a tag is live only if it maps below occ.
// Wrap-safe because occ never exceeds half the tag space.
module obq_tag_xlate
    import obq_ctrl_pkg::*;
(
    input  logic [TAG_W-1:0] tag,
    input  logic [TAG_W-1:0] base,
    input  logic [IDX_W-1:0] occ,
    output logic [IDX_W-1:0] phys,
    output logic             valid
);

    logic [TAG_W-1:0] diff;

    assign diff  = tag - base;
    assign valid = (diff < TAG_W'(occ));
    assign phys  = diff[IDX_W-1:0];

endmodule

// File: rtl/obq_ctrl.sv
// OBQ sequencer: allocates rows, turns mispredicts into clears and retirements into shifts,
// and blocks allocation for the cycle of and after every accepted mispredict.
module obq_ctrl
    import obq_ctrl_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alloc_req,
    output logic                 alloc_ready,
    output logic [TAG_W-1:0]     alloc_tag,
    input  logic                 mp_valid,
    input  logic [TAG_W-1:0]     mp_tag,
    input  logic [RET_CNT_W-1:0] ret_cnt,
    output logic                 write_en,
    output logic                 clear_en,
    output logic [IDX_W-1:0]     index,
    output logic                 shift_en,
    output logic [IDX_W-1:0]     shift_index,
    output logic                 recover,
    output logic [IDX_W-1:0]     occupancy,
    output logic                 err
);

    obq_ctrl_state_t state_q, state_d;
    obq_tag_t        base_q, base_d;
    obq_idx_t        occ_q, occ_d;
    logic            err_q, err_d;

    obq_idx_t        mp_phys;
    logic            mp_hit;
    logic            mp_acc;
    obq_idx_t        eligible;
    obq_idx_t        ret_ext;
    obq_idx_t        shift_amt;
    logic            ret_over;

    obq_tag_xlate u_xlate (
        .tag   (mp_tag),
        .base  (base_q),
        .occ   (occ_q),
        .phys  (mp_phys),
        .valid (mp_hit)
    );

    // Commands are qualified by reset so nothing reaches the OBQ while it is being cleared.
    always_comb begin
        mp_acc      = mp_valid & mp_hit & reset;
        eligible    = mp_acc ? (mp_phys + 1'b1) : occ_q;
        ret_ext     = IDX_W'(ret_cnt);
        ret_over    = (ret_ext > eligible);

        clear_en    = mp_acc;
        index       = mp_acc ? eligible : '0;

        shift_en    = reset & (ret_cnt != '0) & ~ret_over;
        shift_amt   = shift_en ? ret_ext : '0;
        shift_index = shift_en ? (ret_ext - 1'b1) : '0;

        alloc_ready = reset & (state_q == OBQC_NORMAL) & ~mp_acc & (occ_q < IDX_W'(OBQ_SIZE));
        write_en    = alloc_req & alloc_ready;
        alloc_tag   = base_q + TAG_W'(occ_q);

        occ_d       = eligible - shift_amt + IDX_W'(write_en);
        base_d      = base_q + TAG_W'(shift_amt);
        err_d       = err_q | ret_over;
        state_d     = mp_acc ? OBQC_RECOVER : OBQC_NORMAL;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= OBQC_NORMAL;
            base_q  <= '0;
            occ_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            occ_q   <= occ_d;
            err_q   <= err_d;
        end
    end

    assign recover   = (state_q == OBQC_RECOVER);
    assign occupancy = occ_q;
    assign err       = err_q;

endmodule

// File: tb/tb_obq_ctrl.sv
// Self-checking bench for obq_ctrl: directed vector table, hand-written corner sequences,
// and a randomized phase compared against a queue-of-tags reference model every cycle.
module tb_obq_ctrl;
    import obq_ctrl_pkg::*;

    logic                 clock;
    logic                 reset;
    logic                 alloc_req;
    logic                 alloc_ready;
    logic [TAG_W-1:0]     alloc_tag;
    logic                 mp_valid;
    logic [TAG_W-1:0]     mp_tag;
    logic [RET_CNT_W-1:0] ret_cnt;
    logic                 write_en;
    logic                 clear_en;
    logic [IDX_W-1:0]     index;
    logic                 shift_en;
    logic [IDX_W-1:0]     shift_index;
    logic                 recover;
    logic [IDX_W-1:0]     occupancy;
    logic                 err;

    obq_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .alloc_req   (alloc_req),
        .alloc_ready (alloc_ready),
        .alloc_tag   (alloc_tag),
        .mp_valid    (mp_valid),
        .mp_tag      (mp_tag),
        .ret_cnt     (ret_cnt),
        .write_en    (write_en),
        .clear_en    (clear_en),
        .index       (index),
        .shift_en    (shift_en),
        .shift_index (shift_index),
        .recover     (recover),
        .occupancy   (occupancy),
        .err         (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: the OBQ as an ordered list of live logical tags, oldest first.
    int q[$];
    int m_base;
    bit m_rec;
    bit m_err;

    bit p_acc, p_over, p_shift, p_ready, p_write;
    int p_phys, p_tag;

    typedef struct {
        bit pre_rst;
        bit req;
        bit mpv;
        int mtag;
        int ret;
        bit e_ready;
        bit e_wr;
        bit e_clr;
        int e_idx;
        bit e_shift;
        int e_sidx;
        int e_tag;
        int e_occ;
        bit e_rec;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit pre_rst, bit req, bit mpv, int mtag, int ret,
                                bit e_ready, bit e_wr, bit e_clr, int e_idx,
                                bit e_shift, int e_sidx, int e_tag, int e_occ, bit e_rec);
        vec_t v;
        v.pre_rst = pre_rst; v.req = req; v.mpv = mpv; v.mtag = mtag; v.ret = ret;
        v.e_ready = e_ready; v.e_wr = e_wr; v.e_clr = e_clr; v.e_idx = e_idx;
        v.e_shift = e_shift; v.e_sidx = e_sidx; v.e_tag = e_tag; v.e_occ = e_occ;
        v.e_rec = e_rec;
        return v;
    endfunction

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        q.delete();
        m_base = 0;
        m_rec  = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic predict();
        int elig;
        p_acc = 1'b0; p_over = 1'b0; p_shift = 1'b0; p_ready = 1'b0; p_write = 1'b0;
        p_phys = 0;
        p_tag  = (m_base + q.size()) % 64;
        if (reset) begin
            if (mp_valid) begin
                foreach (q[i]) begin
                    if (!p_acc && q[i] == int'(mp_tag)) begin
                        p_acc  = 1'b1;
                        p_phys = i;
                    end
                end
            end
            elig    = p_acc ? p_phys + 1 : q.size();
            p_over  = int'(ret_cnt) > elig;
            p_shift = (ret_cnt != 0) && !p_over;
            p_ready = !m_rec && !p_acc && (q.size() < OBQ_SIZE);
            p_write = alloc_req && p_ready;
        end
    endtask

    task automatic applyStimulus(input bit req, input bit mpv, input int mtag, input int ret);
        @(negedge clock);
        alloc_req = req;
        mp_valid  = mpv;
        mp_tag    = mtag[TAG_W-1:0];
        ret_cnt   = ret[RET_CNT_W-1:0];
        #1;
    endtask

    task automatic checkOutput();
        predict();
        checkVal("alloc_ready", int'(alloc_ready), int'(p_ready));
        checkVal("write_en",    int'(write_en),    int'(p_write));
        checkVal("alloc_tag",   int'(alloc_tag),   p_tag);
        checkVal("clear_en",    int'(clear_en),    int'(p_acc));
        if (p_acc) checkVal("index", int'(index), p_phys + 1);
        checkVal("shift_en",    int'(shift_en),    int'(p_shift));
        if (p_shift) checkVal("shift_index", int'(shift_index), int'(ret_cnt) - 1);
        checkVal("occupancy",   int'(occupancy),   q.size());
        checkVal("recover",     int'(recover),     int'(m_rec));
        checkVal("err",         int'(err),         int'(m_err));
    endtask

    task automatic advance();
        @(posedge clock);
        if (!reset) begin
            modelReset();
        end else begin
            if (p_acc) while (q.size() > p_phys + 1) void'(q.pop_back());
            if (p_shift) begin
                repeat (int'(ret_cnt)) void'(q.pop_front());
                m_base = (m_base + int'(ret_cnt)) % 64;
            end
            if (p_write) q.push_back(p_tag);
            m_rec = p_acc;
            m_err = m_err | p_over;
        end
    endtask

    task automatic step(input bit req, input bit mpv, input int mtag, input int ret);
        applyStimulus(req, mpv, mtag, ret);
        checkOutput();
        advance();
    endtask

    // Active inputs during reset must not leak out as OBQ commands.
    task automatic doReset();
        @(negedge clock);
        reset     = 1'b0;
        alloc_req = 1'b1;
        mp_valid  = 1'b1;
        mp_tag    = '0;
        ret_cnt   = 2'd1;
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        checkOutput();
        @(negedge clock);
        alloc_req = 1'b0;
        mp_valid  = 1'b0;
        ret_cnt   = '0;
        reset     = 1'b1;
    endtask

    initial begin
        int mtag, ret;
        bit req, mpv;

        reset = 1'b1; alloc_req = 1'b0; mp_valid = 1'b0; mp_tag = '0; ret_cnt = '0;
        modelReset();

        // Fill to full, retire two, allocation resumes one cycle later.
        for (int k = 0; k < 16; k++)
            vecs.push_back(mk(k == 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, k, k, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16, 16, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2, 0, 0, 0, 0, 1, 1, 16, 16, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 16, 14, 0));
        // Mispredict on row 3 of 6, recovery stall, stale mispredict ignored.
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(k == 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, k, k, 0));
        vecs.push_back(mk(0, 1, 1, 3, 0, 0, 0, 1, 4, 0, 0, 6, 6, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 4, 1));
        vecs.push_back(mk(0, 0, 1, 5, 0, 1, 0, 0, 0, 0, 0, 4, 4, 0));
        // Build occ=8 base=10, then clear and shift in the same cycle.
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 4 + k, 4 + k, 0));
        for (int j = 0; j < 5; j++)
            vecs.push_back(mk(0, 1, 0, 0, 2, 1, 1, 0, 0, 1, 1, 8 + j, 8 - j, 0));
        for (int j = 0; j < 5; j++)
            vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 13 + j, 3 + j, 0));
        vecs.push_back(mk(0, 0, 1, 14, 2, 0, 0, 1, 5, 1, 1, 18, 8, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15, 3, 1));

        foreach (vecs[n]) begin
            if (vecs[n].pre_rst) doReset();
            applyStimulus(vecs[n].req, vecs[n].mpv, vecs[n].mtag, vecs[n].ret);
            checkOutput();
            checkVal("vec_alloc_ready", int'(alloc_ready), int'(vecs[n].e_ready));
            checkVal("vec_write_en",    int'(write_en),    int'(vecs[n].e_wr));
            checkVal("vec_clear_en",    int'(clear_en),    int'(vecs[n].e_clr));
            if (vecs[n].e_clr)   checkVal("vec_index", int'(index), vecs[n].e_idx);
            checkVal("vec_shift_en",    int'(shift_en),    int'(vecs[n].e_shift));
            if (vecs[n].e_shift) checkVal("vec_shift_index", int'(shift_index), vecs[n].e_sidx);
            checkVal("vec_alloc_tag",   int'(alloc_tag),   vecs[n].e_tag);
            checkVal("vec_occupancy",   int'(occupancy),   vecs[n].e_occ);
            checkVal("vec_recover",     int'(recover),     int'(vecs[n].e_rec));
            advance();
        end

        // Tag wrap: base walks to 62 with occ held at 5, then mispredict tag 1 maps to row 3.
        doReset();
        for (int k = 0; k < 5; k++) step(1, 0, 0, 0);
        for (int k = 0; k < 62; k++) step(1, 0, 0, 1);
        applyStimulus(0, 1, 1, 0);
        checkOutput();
        checkVal("wrap_clear_en", int'(clear_en), 1);
        checkVal("wrap_index",    int'(index),    4);
        advance();
        // Mispredict on the youngest row while still recovering: accepted, occ unchanged.
        applyStimulus(0, 1, 1, 0);
        checkOutput();
        checkVal("youngest_clear_en", int'(clear_en), 1);
        checkVal("youngest_index",    int'(index),    4);
        advance();
        applyStimulus(0, 0, 0, 0);
        checkOutput();
        checkVal("youngest_occ",     int'(occupancy), 4);
        checkVal("youngest_recover", int'(recover),   1);
        advance();

        // Empty queue ignores mispredicts; over-retire sets err and suppresses the shift.
        doReset();
        applyStimulus(0, 1, 0, 0);
        checkOutput();
        checkVal("empty_clear_en", int'(clear_en), 0);
        advance();
        step(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 2);
        checkOutput();
        checkVal("over_shift_en", int'(shift_en), 0);
        advance();
        applyStimulus(0, 0, 0, 0);
        checkOutput();
        checkVal("over_err", int'(err),       1);
        checkVal("over_occ", int'(occupancy), 1);
        advance();

        // Randomized traffic against the model.
        doReset();
        for (int c = 0; c < 600; c++) begin
            req = ($urandom_range(0, 9) < 7);
            mpv = ($urandom_range(0, 9) < 2);
            if (q.size() > 0 && $urandom_range(0, 1) == 1)
                mtag = q[$urandom_range(0, q.size() - 1)];
            else
                mtag = $urandom_range(0, 63);
            ret = $urandom_range(0, 2);
            if (ret > q.size() && $urandom_range(0, 19) != 0) ret = q.size();
            step(req, mpv, mtag, ret);
        end

        // Async reset in the middle of a burst, between clock edges.
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 1);
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        checkVal("async_occupancy",   int'(occupancy),   0);
        checkVal("async_err",         int'(err),         0);
        checkVal("async_recover",     int'(recover),     0);
        checkVal("async_write_en",    int'(write_en),    0);
        checkVal("async_shift_en",    int'(shift_en),    0);
        checkVal("async_alloc_ready", int'(alloc_ready), 0);
        checkVal("async_alloc_tag",   int'(alloc_tag),   0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        alloc_req = 1'b0; ret_cnt = '0; reset = 1'b1;
        step(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput();
        checkVal("post_reset_occ", int'(occupancy), 1);
        advance();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
